mem_port_arbiter: RTL and testbench

- Shares a single memory port between two requesters in the pipelined processor: requester 0 is instruction fetch, requester 1 is load/store.
- Arbitrates round-robin and drives the select of a 32-bit 2:1 mux that steers the granted requester's address and write data onto the port.
- Sequences a fixed-latency access, then returns read data with a one-cycle done pulse.
- The pipeline stalls each stage while its request is pending.

---
 rtl/mem_arb_pkg.sv | 14 +
 rtl/mux_2to1.sv | 13 +
 rtl/mem_port_arbiter.sv | 120 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  localparam logic REQ_FETCH = 1'b0;
  localparam logic REQ_LSU   = 1'b1;
  localparam int   CNT_W     = 4;

endpackage

// File: rtl/mux_2to1.sv
// Width-parameterised 2:1 mux; i_sel=0 passes i_a.
module mux_2to1 #(
  parameter int W = 32
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_sel,
  output logic [W-1:0] o_y
);

  assign o_y = i_sel ? i_b : i_a;

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one fixed-latency memory port between
// instruction fetch (requester 0) and load/store (requester 1).
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int MEM_LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              sel,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              stall0,
  output logic              stall1
);

  arb_state_t        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_sel;
  logic              r_last_grant;
  logic              r_done0;
  logic              r_done1;
  logic [DATA_W-1:0] r_rdata;

  logic w_last_beat;
  logic w_win_idle;
  logic w_other_req;

  assign w_last_beat = (r_cnt == CNT_W'(MEM_LATENCY - 1));
  assign w_win_idle  = (req0 & req1) ? ~r_last_grant : req1;
  // In RESP the served requester still holds req, so only the other one competes.
  assign w_other_req = r_sel ? req0 : req1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_sel        <= REQ_FETCH;
      r_last_grant <= REQ_LSU;
      r_done0      <= 1'b0;
      r_done1      <= 1'b0;
      r_rdata      <= '0;
    end else begin
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      case (r_state)
        IDLE: begin
          if (req0 | req1) begin
            r_state      <= ACCESS;
            r_cnt        <= '0;
            r_sel        <= w_win_idle;
            r_last_grant <= w_win_idle;
          end
        end
        ACCESS: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_last_beat) begin
            r_rdata <= mem_rdata;
            r_state <= RESP;
            r_done0 <= ~r_sel;
            r_done1 <= r_sel;
          end
        end
        RESP: begin
          if (w_other_req) begin
            r_state      <= ACCESS;
            r_cnt        <= '0;
            r_sel        <= ~r_sel;
            r_last_grant <= ~r_sel;
          end else begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  mux_2to1 #(.W(ADDR_W)) u_addr_mux (
    .i_a   (addr0),
    .i_b   (addr1),
    .i_sel (r_sel),
    .o_y   (mem_addr)
  );

  mux_2to1 #(.W(DATA_W)) u_wdata_mux (
    .i_a   (wdata0),
    .i_b   (wdata1),
    .i_sel (r_sel),
    .o_y   (mem_wdata)
  );

  assign mem_en = (r_state == ACCESS);
  assign mem_we = mem_en & (r_sel ? we1 : we0);
  assign sel    = r_sel;
  assign done0  = r_done0;
  assign done1  = r_done1;
  assign rdata  = r_rdata;
  assign busy   = (r_state != IDLE);
  assign stall0 = ~rst & req0 & ~r_done0;
  assign stall1 = ~rst & req1 & ~r_done1;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized checks of mem_port_arbiter against a job/age timeline model.
module tb_mem_port_arbiter;

  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0, mem_rdata = '0;
  logic          mem_en, mem_we, sel, done0, done1, busy, stall0, stall1;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, rdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MEM_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .mem_rdata(mem_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .sel(sel), .done0(done0), .done1(done1), .rdata(rdata), .busy(busy),
    .stall0(stall0), .stall1(stall1)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Model: one job at a time; age 1..LAT = memory cycles, age LAT+1 = done cycle.
  int            m_job  = -1;
  int            m_age  = 0;
  int            m_sel  = 0;
  int            m_last = 1;
  logic [DW-1:0] m_rdata = '0;
  bit            m_init = 0;

  function automatic bit m_done(input int x);
    return (m_job == x) && (m_age == LAT + 1);
  endfunction

  function automatic bit m_en();
    return (m_job >= 0) && (m_age <= LAT);
  endfunction

  task automatic m_grant(input int w);
    m_job  = w;
    m_age  = 1;
    m_sel  = w;
    m_last = w;
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_job = -1; m_age = 0; m_sel = 0; m_last = 1; m_rdata = '0; m_init = 1;
    end else if (m_init) begin
      if (m_job < 0) begin
        if (req0 && req1) m_grant(1 - m_last);
        else if (req0)    m_grant(0);
        else if (req1)    m_grant(1);
      end else if (m_age <= LAT) begin
        if (m_age == LAT) m_rdata = mem_rdata;
        m_age++;
      end else begin
        if ((m_job == 0) ? req1 : req0) m_grant(1 - m_job);
        else m_job = -1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      logic e_en, e_d0, e_d1;
      e_en = m_en();
      e_d0 = m_done(0);
      e_d1 = m_done(1);
      chk("mem_en", {31'b0, mem_en}, {31'b0, e_en});
      chk("mem_we", {31'b0, mem_we}, {31'b0, e_en & ((m_sel == 1) ? we1 : we0)});
      chk("sel",    {31'b0, sel},    32'(m_sel));
      chk("done0",  {31'b0, done0},  {31'b0, e_d0});
      chk("done1",  {31'b0, done1},  {31'b0, e_d1});
      chk("busy",   {31'b0, busy},   {31'b0, m_job >= 0});
      chk("stall0", {31'b0, stall0}, {31'b0, ~rst & req0 & ~e_d0});
      chk("stall1", {31'b0, stall1}, {31'b0, ~rst & req1 & ~e_d1});
      if (e_d0 || e_d1) chk("rdata", rdata, m_rdata);
      if (e_en) begin
        chk("mem_addr",  mem_addr,  (m_sel == 1) ? addr1 : addr0);
        chk("mem_wdata", mem_wdata, (m_sel == 1) ? wdata1 : wdata0);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int order[$];
    mem_rdata = 32'hF0F0_F0F0;

    // Reset held with both requesting
    req0 = 1; req1 = 1;
    cyc(2);
    chk("rst_mem_en", {31'b0, mem_en}, 0);
    chk("rst_done",   {30'b0, done1, done0}, 0);
    chk("rst_sel",    {31'b0, sel}, 0);
    chk("rst_rdata",  rdata, 0);
    chk("rst_busy",   {31'b0, busy}, 0);
    rst = 0;

    // Contention: fetch first, load/store back to back
    cyc(1);
    chk("cont_sel0", {31'b0, sel}, 0);
    chk("cont_en0",  {31'b0, mem_en}, 1);
    cyc(2);
    chk("cont_done0", {31'b0, done0}, 1);
    chk("cont_rdata", rdata, 32'hF0F0_F0F0);
    req0 = 0;
    cyc(1);
    chk("cont_sel1", {31'b0, sel}, 1);
    chk("cont_en1",  {31'b0, mem_en}, 1);
    cyc(2);
    chk("cont_done1", {31'b0, done1}, 1);
    req1 = 0;
    cyc(1);
    chk("cont_idle", {31'b0, busy}, 0);

    // Single read
    addr0 = 32'h10; req0 = 1;
    cyc(1);
    chk("rd_en",   {31'b0, mem_en}, 1);
    chk("rd_addr", mem_addr, 32'h10);
    chk("rd_sel",  {31'b0, sel}, 0);
    cyc(1);
    chk("rd_en2",  {31'b0, mem_en}, 1);
    chk("rd_nodone", {31'b0, done0}, 0);
    cyc(1);
    chk("rd_done",  {31'b0, done0}, 1);
    chk("rd_rdata", rdata, 32'hF0F0_F0F0);
    chk("rd_en_off", {31'b0, mem_en}, 0);
    req0 = 0;
    cyc(1);

    // Single write
    we1 = 1; addr1 = 32'h20; wdata1 = 32'h8000_0001; req1 = 1;
    cyc(1);
    chk("wr_sel",   {31'b0, sel}, 1);
    chk("wr_we",    {31'b0, mem_we}, 1);
    chk("wr_wdata", mem_wdata, 32'h8000_0001);
    chk("wr_addr",  mem_addr, 32'h20);
    cyc(1);
    chk("wr_we2",   {31'b0, mem_we}, 1);
    cyc(1);
    chk("wr_done",  {31'b0, done1}, 1);
    req1 = 0; we1 = 0;
    cyc(1);

    // Fairness with both held continuously
    req0 = 1; req1 = 1;
    for (int i = 0; i < 40; i++) begin
      cyc(1);
      if (done0) order.push_back(0);
      if (done1) order.push_back(1);
    end
    chk("fair_cnt", {31'b0, order.size() >= 6}, 1);
    for (int i = 0; i < 6 && i < order.size(); i++)
      chk("fair_order", 32'(order[i]), 32'(i % 2));
    req0 = 0; req1 = 0;
    cyc(6);
    chk("fair_idle", {31'b0, busy}, 0);

    // Reset in the second ACCESS cycle
    req0 = 1;
    cyc(2);
    chk("mrst_en", {31'b0, mem_en}, 1);
    rst = 1;
    cyc(1);
    chk("mrst_idle", {31'b0, busy}, 0);
    chk("mrst_nodone", {31'b0, done0}, 0);
    rst = 0;
    cyc(1);
    chk("mrst_re_en", {31'b0, mem_en}, 1);
    cyc(1);
    chk("mrst_nodone2", {31'b0, done0}, 0);
    cyc(1);
    chk("mrst_done", {31'b0, done0}, 1);
    req0 = 0;
    cyc(1);

    // Randomized traffic with occasional resets
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 149) == 0);
      mem_rdata = $urandom;
      if (!req0) begin
        if ($urandom_range(0, 2) == 0) begin
          req0 = 1; we0 = ($urandom_range(0, 7) == 0);
          addr0 = $urandom; wdata0 = $urandom;
        end
      end else if (m_done(0)) begin
        if ($urandom_range(0, 1) == 0) req0 = 0;
        else begin addr0 = $urandom; wdata0 = $urandom; end
      end
      if (!req1) begin
        if ($urandom_range(0, 2) == 0) begin
          req1 = 1; we1 = $urandom_range(0, 1);
          addr1 = $urandom; wdata1 = $urandom;
        end
      end else if (m_done(1)) begin
        if ($urandom_range(0, 1) == 0) req1 = 0;
        else begin we1 = $urandom_range(0, 1); addr1 = $urandom; wdata1 = $urandom; end
      end
      cyc(1);
    end

    rst = 0; req0 = 0; req1 = 0;
    cyc(8);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
